// File: rtl/led_sync_fifo.sv
// rtl/led_sync_fifo.sv - parametrised single-clock FIFO with thresholds, FWFT mode, flush and sticky error flags
module led_sync_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 10,
    parameter bit FWFT        = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_full,
    output logic                   almost_full,
    input  logic [DEPTH_WIDTH:0]   af_thresh,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic                   rd_empty,
    output logic                   almost_empty,
    input  logic [DEPTH_WIDTH:0]   ae_thresh,
    output logic [DEPTH_WIDTH:0]   water_level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] LVL_FULL = {1'b1, {DEPTH_WIDTH{1'b0}}};
    localparam logic [DEPTH_WIDTH:0] LVL_ONE  = {{DEPTH_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_WIDTH:0]   level_q, level_d;
    logic [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic                   valid_q, valid_d;
    logic                   full_q, full_d, empty_q, empty_d;
    logic                   ovf_q, ovf_d, unf_q, unf_d;
    logic                   wr_acc, rd_acc, ram_empty, ram_rd;

    always_comb begin
        wr_acc    = wr_en && !full_q;
        rd_acc    = rd_en && !empty_q;
        ram_empty = (wr_ptr_q == rd_ptr_q);
        // In FWFT the output stage refills itself whenever it is empty or being popped.
        if (FWFT) ram_rd = !ram_empty && (!valid_q || rd_acc);
        else      ram_rd = rd_acc;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            valid_d  = 1'b0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + LVL_ONE;
            if (ram_rd) begin
                rd_ptr_d = rd_ptr_q + LVL_ONE;
                dout_d   = mem_q[rd_ptr_q[DEPTH_WIDTH-1:0]];
            end
            if (FWFT) valid_d = ram_rd || (valid_q && !rd_acc);
            else      valid_d = rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
            if (wr_en && full_q)  ovf_d = 1'b1;
            if (rd_en && empty_q) unf_d = 1'b1;
        end

        full_d  = (level_d == LVL_FULL);
        empty_d = FWFT ? !valid_d : (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!flush && wr_acc) mem_q[wr_ptr_q[DEPTH_WIDTH-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign wr_full      = full_q;
    assign rd_empty     = empty_q;
    assign rd_data      = dout_q;
    assign rd_valid     = valid_q;
    assign water_level  = level_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign almost_full  = (level_q >= af_thresh);
    assign almost_empty = (level_q <= ae_thresh);

endmodule

// File: tb/tb_led_sync_fifo.sv
// tb/tb_led_sync_fifo.sv - scoreboard bench for led_sync_fifo in standard and FWFT modes
module tb_led_sync_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       s_flush = 0, s_wr_en = 0, s_rd_en = 0;
    logic [7:0] s_wr_data = 0, s_rd_data;
    logic [4:0] s_af = 5'd12, s_ae = 5'd3, s_level;
    logic       s_full, s_afull, s_valid, s_empty, s_aempty, s_ovf, s_unf;

    logic       f_flush = 0, f_wr_en = 0, f_rd_en = 0;
    logic [7:0] f_wr_data = 0, f_rd_data;
    logic [4:0] f_af = 5'd0, f_ae = 5'd0, f_level;
    logic       f_full, f_afull, f_valid, f_empty, f_aempty, f_ovf, f_unf;

    logic [7:0] s_exp_q[$];
    logic [7:0] f_exp_q[$];

    led_sync_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(4), .FWFT(1'b0)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(s_flush),
        .wr_en(s_wr_en), .wr_data(s_wr_data), .wr_full(s_full),
        .almost_full(s_afull), .af_thresh(s_af),
        .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_valid), .rd_empty(s_empty),
        .almost_empty(s_aempty), .ae_thresh(s_ae), .water_level(s_level),
        .overflow(s_ovf), .underflow(s_unf)
    );

    led_sync_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(4), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(f_flush),
        .wr_en(f_wr_en), .wr_data(f_wr_data), .wr_full(f_full),
        .almost_full(f_afull), .af_thresh(f_af),
        .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_valid), .rd_empty(f_empty),
        .almost_empty(f_aempty), .ae_thresh(f_ae), .water_level(f_level),
        .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the expected word whenever a DUT presents/hands over a word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid) begin
                if (s_exp_q.size() == 0) chk("std_unexpected_valid", 32'(s_rd_data), 32'hFFFF_FFFF);
                else chk("std_data", 32'(s_rd_data), 32'(s_exp_q.pop_front()));
            end
            if (f_rd_en) begin
                chk("fwft_pop_valid", 32'(f_valid), 32'd1);
                if (f_valid) begin
                    if (f_exp_q.size() == 0) chk("fwft_unexpected_pop", 32'(f_rd_data), 32'hFFFF_FFFF);
                    else chk("fwft_data", 32'(f_rd_data), 32'(f_exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst_full", 32'(s_full), 32'd0);
        chk("rst_empty", 32'(s_empty), 32'd1);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_data", 32'(s_rd_data), 32'd0);
        chk("rst_level", 32'(s_level), 32'd0);
        chk("rst_ovf_unf", 32'({s_ovf, s_unf}), 32'd0);
        chk("rst_aempty", 32'(s_aempty), 32'd1);
        chk("rst_afull_thr12", 32'(s_afull), 32'd0);
        chk("rst_afull_thr0", 32'(f_afull), 32'd1);
        rst_n = 1'b1;
        tick();

        // Fill 0x00..0x0F and watch the thresholds (ae=3, af=12).
        for (int i = 0; i < 16; i++) begin
            s_wr_en = 1; s_wr_data = 8'(i);
            tick();
            chk("fill_level", 32'(s_level), 32'(i + 1));
            chk("fill_aempty", 32'(s_aempty), 32'((i + 1) <= 3));
            chk("fill_afull", 32'(s_afull), 32'((i + 1) >= 12));
            chk("fill_full", 32'(s_full), 32'(i == 15));
        end
        s_wr_data = 8'hAA;
        tick();
        s_wr_en = 0;
        chk("ovf_set", 32'(s_ovf), 32'd1);
        chk("ovf_level", 32'(s_level), 32'd16);
        s_af = 5'd20;
        #1;
        chk("afull_thr20", 32'(s_afull), 32'd0);
        s_af = 5'd12;

        // Full with wr+rd: read wins, write of 0xBB is dropped.
        s_wr_en = 1; s_wr_data = 8'hBB; s_rd_en = 1;
        s_exp_q.push_back(8'h00);
        tick();
        s_wr_en = 0;
        chk("full_wrrd_level", 32'(s_level), 32'd15);
        chk("full_wrrd_valid", 32'(s_valid), 32'd1);
        for (int i = 1; i < 16; i++) begin
            s_exp_q.push_back(8'(i));
            tick();
            chk("drain_valid", 32'(s_valid), 32'd1);
        end
        s_rd_en = 0;
        chk("drain_empty", 32'(s_empty), 32'd1);
        chk("drain_level", 32'(s_level), 32'd0);
        tick();
        chk("idle_valid", 32'(s_valid), 32'd0);
        chk("hold_data", 32'(s_rd_data), 32'h0F);

        s_rd_en = 1;
        tick();
        s_rd_en = 0;
        chk("unf_set", 32'(s_unf), 32'd1);
        tick();
        chk("unf_no_valid", 32'(s_valid), 32'd0);
        s_flush = 1;
        tick();
        s_flush = 0;
        chk("flush_flags", 32'({s_ovf, s_unf}), 32'd0);
        chk("flush_level", 32'(s_level), 32'd0);

        // Empty with wr+rd: write accepted, read rejected.
        s_wr_en = 1; s_wr_data = 8'h30; s_rd_en = 1;
        tick();
        s_rd_en = 0;
        chk("empty_wrrd_level", 32'(s_level), 32'd1);
        chk("empty_wrrd_unf", 32'(s_unf), 32'd1);
        for (int i = 1; i < 5; i++) begin
            s_wr_data = 8'(8'h30 + i);
            tick();
        end
        chk("lvl5", 32'(s_level), 32'd5);
        s_rd_en = 1;
        for (int i = 0; i < 40; i++) begin
            s_wr_data = 8'(8'h35 + i);
            s_exp_q.push_back(8'(8'h30 + i));
            tick();
            chk("steady_level", 32'(s_level), 32'd5);
        end
        s_wr_en = 0;
        for (int i = 0; i < 5; i++) begin
            s_exp_q.push_back(8'(8'h58 + i));
            tick();
        end
        s_rd_en = 0;
        tick();
        chk("wrap_empty", 32'(s_empty), 32'd1);

        // FWFT: head appears two cycles after the write with no rd_en.
        f_wr_en = 1; f_wr_data = 8'h11;
        tick();
        f_wr_en = 0;
        chk("fwft_empty_1cyc", 32'(f_empty), 32'd1);
        chk("fwft_level_1cyc", 32'(f_level), 32'd1);
        tick();
        chk("fwft_empty_2cyc", 32'(f_empty), 32'd0);
        chk("fwft_head", 32'(f_rd_data), 32'h11);
        chk("fwft_valid", 32'(f_valid), 32'd1);
        f_rd_en = 1;
        f_exp_q.push_back(8'h11);
        tick();
        f_rd_en = 0;
        chk("fwft_pop_empty", 32'(f_empty), 32'd1);
        f_wr_en = 1;
        for (int i = 0; i < 8; i++) begin
            f_wr_data = 8'(8'h20 + i);
            tick();
        end
        f_wr_en = 0;
        chk("fwft_level8", 32'(f_level), 32'd8);
        f_rd_en = 1;
        for (int i = 0; i < 8; i++) begin
            f_exp_q.push_back(8'(8'h20 + i));
            tick();
        end
        f_rd_en = 0;
        chk("fwft_drain_empty", 32'(f_empty), 32'd1);
        chk("fwft_drain_level", 32'(f_level), 32'd0);

        // Reset mid-stream at level 9.
        s_wr_en = 1;
        for (int i = 0; i < 9; i++) begin
            s_wr_data = 8'(8'h60 + i);
            tick();
        end
        s_wr_en = 0;
        chk("pre_rst_level", 32'(s_level), 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(s_level), 32'd0);
        chk("arst_empty", 32'(s_empty), 32'd1);
        chk("arst_data", 32'(s_rd_data), 32'd0);
        chk("arst_flags", 32'({s_full, s_valid, s_ovf, s_unf}), 32'd0);
        chk("arst_aempty", 32'(s_aempty), 32'd1);
        #1;
        rst_n = 1'b1;
        tick();
        s_wr_en = 1; s_wr_data = 8'h5C;
        tick();
        s_wr_en = 0; s_rd_en = 1;
        s_exp_q.push_back(8'h5C);
        tick();
        s_rd_en = 0;
        tick();
        tick();

        chk("std_queue_drained", 32'(s_exp_q.size()), 32'd0);
        chk("fwft_queue_drained", 32'(f_exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_sync_fifo.md
# led_sync_fifo

Parametrised single-clock FIFO for the local-dimming LED datapath. It replaces the fixed 8-bit × 1024 generated FIFO with a block whose width and depth are set by parameters. It adds runtime-programmable almost-full/almost-empty thresholds, a live water level, a first-word-fall-through (FWFT) read mode, a synchronous flush, and sticky overflow/underflow error flags. It sits between the backlight statistics stage and the LED driver serialiser.

## Interface
- DATA_WIDTH, 8, word width (1..256)
- DEPTH_WIDTH, 10, log2 of capacity; capacity DEPTH = 2**DEPTH_WIDTH (4..16)
- FWFT, 0, read mode: 0 = standard (data one cycle after rd_en), 1 = first-word-fall-through

- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of contents and error flags
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- wr_full  out  1  level == DEPTH
- almost_full  out  1  level >= af_thresh
- af_thresh  in  DEPTH_WIDTH+1  almost-full threshold, quasi-static
- rd_en  in  1  read request (standard) / pop acknowledge (FWFT)
- rd_data  out  DATA_WIDTH  read word
- rd_valid  out  1  rd_data holds a freshly read word (standard) / head word present (FWFT)
- rd_empty  out  1  no readable word
- almost_empty  out  1  level <= ae_thresh
- ae_thresh  in  DEPTH_WIDTH+1  almost-empty threshold, quasi-static
- water_level  out  DEPTH_WIDTH+1  words currently held, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH-entry RAM. Write and read pointers are DEPTH_WIDTH+1 bits with wrap bit. Level is a registered counter.
- Write accepted iff wr_en && !wr_full. Read accepted iff rd_en && !rd_empty.
- Full with simultaneous wr_en and rd_en: the read is accepted and the write is rejected, so level drops by 1.
- Empty with simultaneous wr_en and rd_en: the write is accepted and the read is rejected.
- Otherwise, simultaneous accepted read and write leave the level unchanged.
- Rejected write sets overflow. Rejected read sets underflow. Both stay set until flush or reset.
- Flush has priority over wr_en and rd_en in the same cycle. It zeroes pointers and level, clears overflow, underflow and rd_valid, empties the FWFT output stage, and leaves rd_data unchanged.
- Standard mode: an accepted read presents the word on rd_data in the next cycle with rd_valid high for one cycle. rd_data holds between reads.
- FWFT mode: a prefetch stage keeps the head word on rd_data whenever rd_empty = 0, and rd_valid = !rd_empty. Asserting rd_en pops the head, and the next word (if any) appears in the following cycle without a bubble.
- The FWFT output stage counts toward water_level. Capacity is DEPTH in both modes.
- Thresholds: almost_full = (level >= af_thresh), so af_thresh = 0 forces it high. almost_empty = (level <= ae_thresh). Thresholds are sampled continuously and may change at any time; the flags follow in the same cycle as the change.
- Pointer wrap past DEPTH-1 must be seamless; data order is preserved across wrap.

## Timing
- Reset values: wr_full 0, rd_empty 1, rd_valid 0, rd_data 0, water_level 0, overflow 0, underflow 0, almost_empty 1, almost_full = (af_thresh == 0).
- water_level, wr_full and rd_empty are registered.
- almost_full and almost_empty are combinational from registered level plus thresholds.
- Write accepted at edge N: water_level and wr_full update at N+1.
- Standard: a write into an empty FIFO at edge N gives rd_empty = 0 after N+1. rd_en sampled at M gives rd_data/rd_valid after M+1.
- FWFT: a write into an empty FIFO at edge N gives rd_data valid and rd_empty = 0 after N+2.
- Sustained full rate in both modes: one write and one read per cycle.
- Reset mid-operation: asynchronous clear of all state to the reset values. RAM contents are don't-care.

## Test plan
- Standard mode, DEPTH_WIDTH=4: write 0x00..0x0F, then read 16 -> data 0x00..0x0F in order, rd_valid one cycle after each rd_en, wr_full high at level 16, rd_empty high after the last read.
- Overflow/underflow: fill 16, one extra write with the value 0xAA -> overflow = 1, 0xAA never read. One read while empty -> underflow = 1. Flush -> both flags 0 and water_level 0.
- Thresholds: af_thresh = 12, ae_thresh = 3. Write one by one -> almost_empty drops when level reaches 4 and almost_full rises when level reaches 12. Change af_thresh to 20 -> almost_full = 0 immediately.
- Simultaneous events:
  - At full with wr+rd -> level 15 and the write is dropped.
  - At empty with wr+rd -> level 1 and underflow = 1.
  - At level 5 with wr+rd for 40 cycles (wrap twice) -> level stays 5 and output order is intact.
- FWFT mode: write 0x11 into an empty FIFO -> rd_data = 0x11 with rd_empty = 0 two cycles later and no rd_en needed. Back-to-back pops of 8 words -> one word per cycle, no gaps.
- Reset mid-stream: deassert rst_n at level 9 -> all outputs return to their reset values asynchronously. After release, a write/read of 0x5C returns 0x5C.
